branch_resolve_pipe: RTL and testbench

Carries each fetch-time branch prediction (PC, predicted direction, PHT index) from the fetch stage through decode to execute. In execute it compares the prediction with the resolved outcome and drives the training and recovery signals (branchE, PHT_indexE, actually_takenE, predict_resultE) back into the global-history predictor. It also drives the mispredict redirect and flush request to the fetch/hazard logic and keeps branch/mispredict statistics counters.

---
 rtl/bp_pkg.sv | 19 +
 rtl/bp_pipe_reg.sv | 30 +++
 rtl/branch_resolve_pipe.sv | 102 ++++++++++
 tb/tb_branch_resolve_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Branch-prediction bookkeeping types shared by the predictor, datapath and resolve pipe.
package bp_pkg;

  localparam int unsigned BP_PHT_INDEX_BITS = 10;
  localparam int unsigned BP_PC_BITS        = 32;
  localparam int unsigned BP_CNT_BITS       = 32;

  // Fall-through PC on a not-taken branch skips the delay slot.
  localparam logic [BP_PC_BITS-1:0] BP_FALLTHRU_OFFSET = BP_PC_BITS'(8);

  // Prediction context carried alongside an instruction from fetch to execute.
  typedef struct packed {
    logic [BP_PC_BITS-1:0]        pc;
    logic                         predict_take;
    logic [BP_PHT_INDEX_BITS-1:0] pht_index;
    logic                         branch;
  } bp_info_t;

endpackage

// File: rtl/bp_pipe_reg.sv
// Pipeline register for {valid, prediction context} with hold and flush.
module bp_pipe_reg
  import bp_pkg::*;
#(
  parameter type payload_t = bp_info_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     stall,
  input  logic     flush,
  input  logic     valid_in,
  input  payload_t data_in,
  output logic     valid,
  output payload_t data
);

  // Priority rst > flush > stall > load; flush only clears valid, payload is don't-care.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!stall) begin
      valid <= valid_in;
      data  <= data_in;
    end
  end

endmodule

// File: rtl/branch_resolve_pipe.sv
// Carries fetch predictions to execute, resolves them, and feeds training/redirect/statistics.
module branch_resolve_pipe
  import bp_pkg::*;
#(
  parameter int unsigned PHT_INDEX_BITS = BP_PHT_INDEX_BITS,
  parameter int unsigned CNT_BITS       = BP_CNT_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stallD,
  input  logic                      flushD,
  input  logic                      stallE,
  input  logic                      flushE,
  input  logic [31:0]               pcF,
  input  logic                      predict_takeF,
  input  logic [PHT_INDEX_BITS-1:0] PHT_indexF,
  input  logic                      branchD,
  input  logic                      actually_takenE_in,
  input  logic [31:0]               branch_targetE,
  output logic                      branchE,
  output logic [PHT_INDEX_BITS-1:0] PHT_indexE,
  output logic                      actually_takenE,
  output logic                      predict_takeE,
  output logic                      predict_resultE,
  output logic                      mispredictE,
  output logic [31:0]               redirect_pcE,
  output logic [CNT_BITS-1:0]       branch_cnt,
  output logic [CNT_BITS-1:0]       mispredict_cnt
);

  bp_info_t info_f;
  bp_info_t info_d;
  bp_info_t info_d_tagged;
  bp_info_t info_e;
  logic     valid_d;
  logic     valid_e;
  logic     retire;
  logic     mispredict;

  // Fetch-side payload; the branch flag is only known after decode.
  always_comb begin
    info_f              = '0;
    info_f.pc           = pcF;
    info_f.predict_take = predict_takeF;
    info_f.pht_index    = BP_PHT_INDEX_BITS'(PHT_indexF);
    info_f.branch       = 1'b0;
  end

  bp_pipe_reg #(.payload_t(bp_info_t)) u_reg_fd (
    .clk      (clk),
    .rst      (rst),
    .stall    (stallD),
    .flush    (flushD),
    .valid_in (1'b1),
    .data_in  (info_f),
    .valid    (valid_d),
    .data     (info_d)
  );

  // Decode marks the entry as a conditional branch.
  always_comb begin
    info_d_tagged        = info_d;
    info_d_tagged.branch = valid_d & branchD;
  end

  bp_pipe_reg #(.payload_t(bp_info_t)) u_reg_de (
    .clk      (clk),
    .rst      (rst),
    .stall    (stallE),
    .flush    (flushE),
    .valid_in (valid_d),
    .data_in  (info_d_tagged),
    .valid    (valid_e),
    .data     (info_e)
  );

  // Resolve in E: a stalled branch retires only on the cycle the stall drops.
  always_comb begin
    retire          = valid_e & info_e.branch & ~stallE;
    mispredict      = retire & (info_e.predict_take != actually_takenE_in);
    branchE         = retire;
    mispredictE     = mispredict;
    predict_resultE = ~mispredict;
    actually_takenE = actually_takenE_in;
    predict_takeE   = info_e.predict_take;
    PHT_indexE      = PHT_INDEX_BITS'(info_e.pht_index);
    redirect_pcE    = actually_takenE_in ? branch_targetE
                                         : info_e.pc + BP_FALLTHRU_OFFSET;
  end

  // Retired-branch and mispredict statistics, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (retire)     branch_cnt     <= branch_cnt + CNT_BITS'(1);
      if (mispredict) mispredict_cnt <= mispredict_cnt + CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_pipe.sv
// Directed bench for branch_resolve_pipe with a cycle-level reference model.
module tb_branch_resolve_pipe;

  logic        clk;
  logic        rst;
  logic        stallD, flushD, stallE, flushE;
  logic [31:0] pcF;
  logic        predict_takeF;
  logic [9:0]  PHT_indexF;
  logic        branchD;
  logic        actually_takenE_in;
  logic [31:0] branch_targetE;
  logic        branchE;
  logic [9:0]  PHT_indexE;
  logic        actually_takenE;
  logic        predict_takeE;
  logic        predict_resultE;
  logic        mispredictE;
  logic [31:0] redirect_pcE;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  branch_resolve_pipe dut (
    .clk                (clk),
    .rst                (rst),
    .stallD             (stallD),
    .flushD             (flushD),
    .stallE             (stallE),
    .flushE             (flushE),
    .pcF                (pcF),
    .predict_takeF      (predict_takeF),
    .PHT_indexF         (PHT_indexF),
    .branchD            (branchD),
    .actually_takenE_in (actually_takenE_in),
    .branch_targetE     (branch_targetE),
    .branchE            (branchE),
    .PHT_indexE         (PHT_indexE),
    .actually_takenE    (actually_takenE),
    .predict_takeE      (predict_takeE),
    .predict_resultE    (predict_resultE),
    .mispredictE        (mispredictE),
    .redirect_pcE       (redirect_pcE),
    .branch_cnt         (branch_cnt),
    .mispredict_cnt     (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference model: what sits in D and E, and how many branches have retired.
  typedef struct {
    bit        v;
    bit [31:0] pc;
    bit        pt;
    bit [9:0]  idx;
    bit        br;
  } slot_t;

  slot_t       m_d, m_e;
  int unsigned m_bcnt, m_mcnt;
  bit          started = 1'b0;

  function automatic bit m_retiring();
    return m_e.v && m_e.br && !stallE;
  endfunction

  function automatic bit m_wrong();
    return m_retiring() && (m_e.pt != actually_takenE_in);
  endfunction

  always @(posedge clk) begin
    slot_t fetched;
    if (rst) begin
      m_d    = '{default: 0};
      m_e    = '{default: 0};
      m_bcnt = 0;
      m_mcnt = 0;
      started = 1'b1;
    end else begin
      if (m_retiring()) m_bcnt = m_bcnt + 1;
      if (m_wrong())    m_mcnt = m_mcnt + 1;
      if (flushE)       m_e.v = 1'b0;
      else if (!stallE) begin
        m_e    = m_d;
        m_e.br = m_d.v && branchD;
      end
      fetched = '{v: 1'b1, pc: pcF, pt: predict_takeF, idx: PHT_indexF, br: 1'b0};
      if (flushD)       m_d.v = 1'b0;
      else if (!stallD) m_d = fetched;
    end
  end

  // Every cycle: outputs must agree with the model.
  always @(negedge clk) begin
    if (started && !rst) begin
      bit        exp_wrong;
      bit [31:0] exp_redir;
      exp_wrong = m_wrong();
      exp_redir = actually_takenE_in ? branch_targetE : m_e.pc + 32'd8;
      chk("m_branchE", 32'(branchE), 32'(m_retiring()));
      chk("m_mispredictE", 32'(mispredictE), 32'(exp_wrong));
      chk("m_predict_resultE", 32'(predict_resultE), 32'(!exp_wrong));
      chk("m_actually_takenE", 32'(actually_takenE), 32'(actually_takenE_in));
      chk("m_branch_cnt", branch_cnt, m_bcnt);
      chk("m_mispredict_cnt", mispredict_cnt, m_mcnt);
      if (m_e.v) begin
        chk("m_PHT_indexE", 32'(PHT_indexE), 32'(m_e.idx));
        chk("m_predict_takeE", 32'(predict_takeE), 32'(m_e.pt));
      end
      if (exp_wrong) chk("m_redirect_pcE", redirect_pcE, exp_redir);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Fetch a prediction, tag it as a branch in D, return with it sitting in E.
  task automatic issue(input logic [31:0] pc, input logic pt, input logic [9:0] idx);
    pcF = pc; predict_takeF = pt; PHT_indexF = idx; branchD = 1'b0;
    cyc();
    branchD = 1'b1; pcF = pc + 32'd4; predict_takeF = 1'b0; PHT_indexF = 10'h0;
    cyc();
    branchD = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stallD = 0; flushD = 0; stallE = 0; flushE = 0;
    pcF = 0; predict_takeF = 0; PHT_indexF = 0; branchD = 0;
    actually_takenE_in = 0; branch_targetE = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_redirect_pcE", redirect_pcE, 32'h8);
    chk("rst_predict_resultE", 32'(predict_resultE), 32'h1);
    chk("rst_PHT_indexE", 32'(PHT_indexE), 32'h0);
    rst = 1'b0;

    // Idle: fetch stream of non-branches.
    repeat (10) cyc();
    @(negedge clk);
    chk("idle_predict_resultE", 32'(predict_resultE), 32'h1);
    chk("idle_branchE", 32'(branchE), 32'h0);
    chk("idle_branch_cnt", branch_cnt, 32'h0);

    // Correct taken prediction.
    issue(32'h100, 1'b1, 10'h040);
    actually_takenE_in = 1'b1; branch_targetE = 32'h3000;
    @(negedge clk);
    chk("hit_branchE", 32'(branchE), 32'h1);
    chk("hit_PHT_indexE", 32'(PHT_indexE), 32'h040);
    chk("hit_predict_resultE", 32'(predict_resultE), 32'h1);
    cyc();
    actually_takenE_in = 1'b0;
    @(negedge clk);
    chk("hit_branch_cnt", branch_cnt, 32'h1);

    // Predicted taken, resolved not taken.
    issue(32'h100, 1'b1, 10'h040);
    actually_takenE_in = 1'b0;
    @(negedge clk);
    chk("miss_mispredictE", 32'(mispredictE), 32'h1);
    chk("miss_predict_resultE", 32'(predict_resultE), 32'h0);
    chk("miss_redirect_pcE", redirect_pcE, 32'h108);
    cyc();
    @(negedge clk);
    chk("miss_mispredict_cnt", mispredict_cnt, 32'h1);

    // Predicted not taken, resolved taken.
    issue(32'h200, 1'b0, 10'h003);
    actually_takenE_in = 1'b1; branch_targetE = 32'h2000;
    @(negedge clk);
    chk("taken_redirect_pcE", redirect_pcE, 32'h2000);
    cyc();
    actually_takenE_in = 1'b0;

    // Fall-through past the top of the address space wraps.
    issue(32'hFFFF_FFFC, 1'b1, 10'h005);
    actually_takenE_in = 1'b0;
    @(negedge clk);
    chk("wrap_redirect_pcE", redirect_pcE, 32'h4);
    cyc();
    @(negedge clk);
    chk("wrap_branch_cnt", branch_cnt, 32'h4);
    chk("wrap_mispredict_cnt", mispredict_cnt, 32'h3);

    // Branch held in E for three cycles retires exactly once.
    issue(32'h300, 1'b1, 10'h007);
    actually_takenE_in = 1'b1; branch_targetE = 32'h3400; stallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_branchE_low", 32'(branchE), 32'h0);
      cyc();
    end
    stallE = 1'b0;
    @(negedge clk);
    chk("stall_branchE_high", 32'(branchE), 32'h1);
    cyc();
    actually_takenE_in = 1'b0;
    @(negedge clk);
    chk("stall_branchE_after", 32'(branchE), 32'h0);
    chk("stall_branch_cnt", branch_cnt, 32'h5);

    // flushE while the branch is in D: it never reaches E.
    pcF = 32'h400; predict_takeF = 1'b1; PHT_indexF = 10'h009;
    cyc();
    branchD = 1'b1; flushE = 1'b1; pcF = 32'h404; predict_takeF = 1'b0;
    cyc();
    branchD = 1'b0; flushE = 1'b0;
    @(negedge clk);
    chk("flush_branchE", 32'(branchE), 32'h0);

    // flushE and stallE together: flush wins.
    pcF = 32'h500; predict_takeF = 1'b1; PHT_indexF = 10'h00B;
    cyc();
    branchD = 1'b1; flushE = 1'b1; stallE = 1'b1; pcF = 32'h504; predict_takeF = 1'b0;
    cyc();
    branchD = 1'b0; flushE = 1'b0; stallE = 1'b0;
    @(negedge clk);
    chk("flushstall_branchE", 32'(branchE), 32'h0);
    cyc();
    @(negedge clk);
    chk("flush_branch_cnt", branch_cnt, 32'h5);
    chk("flush_mispredict_cnt", mispredict_cnt, 32'h3);

    // Reset with a mispredicting branch in E.
    issue(32'h600, 1'b1, 10'h00A);
    actually_takenE_in = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rstmid_branchE", 32'(branchE), 32'h0);
    chk("rstmid_mispredictE", 32'(mispredictE), 32'h0);
    chk("rstmid_predict_resultE", 32'(predict_resultE), 32'h1);
    chk("rstmid_redirect_pcE", redirect_pcE, 32'h8);
    chk("rstmid_PHT_indexE", 32'(PHT_indexE), 32'h0);
    chk("rstmid_predict_takeE", 32'(predict_takeE), 32'h0);
    chk("rstmid_branch_cnt", branch_cnt, 32'h0);
    chk("rstmid_mispredict_cnt", mispredict_cnt, 32'h0);

    repeat (4) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
